// File: rtl/sargantana_dcache_req_arbiter.sv
// sargantana_dcache_req_arbiter: round-robin sharing of one HPDCache port with SID tagging, abort forwarding and per-client throttling
// Define SARGANTANA_DCACHE_ARB_PRIO_EN to give requester 0 (PTW) fixed priority over the round-robin set.
module sargantana_dcache_req_arbiter #(
  parameter int NREQ            = 2,
  parameter int REQ_W           = 128,
  parameter int RSP_W           = 96,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SID_W          = $clog2(NREQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*REQ_W-1:0]   req_data_i,
  input  logic [NREQ*TAG_W-1:0]   req_tag_i,
  input  logic [NREQ-1:0]         req_abort_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic [RSP_W-1:0]        rsp_data_o,
  output logic [TAG_W-1:0]        rsp_tag_o,
  output logic                    dc_req_valid_o,
  input  logic                    dc_req_ready_i,
  output logic [REQ_W-1:0]        dc_req_data_o,
  output logic [SID_W+TAG_W-1:0]  dc_req_tag_o,
  output logic                    dc_req_abort_o,
  input  logic                    dc_rsp_valid_i,
  input  logic [RSP_W-1:0]        dc_rsp_data_i,
  input  logic [SID_W+TAG_W-1:0]  dc_rsp_tag_i
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
`ifdef SARGANTANA_DCACHE_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif
  logic [SID_W-1:0] rr_ptr, lock_sid, abort_sid, g, g_rr, rsp_sid;
  logic lock, abort_vld, hs;
  logic [NREQ-1:0] elig;
  logic [CNT_W-1:0] cnt [NREQ];
  // Walk the ring backwards so the nearest eligible index after rr_ptr is the last write.
  always_comb begin
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid_i[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    g_rr = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      automatic int j = (int'(rr_ptr) + k) % NREQ;
      if (elig[j] && !(PRIO_EN && j == 0)) g_rr = SID_W'(j);
    end
    g = lock ? lock_sid : (PRIO_EN && elig[0]) ? '0 : g_rr;
  end
  assign dc_req_valid_o = !rst_i && (|elig || lock);
  assign hs             = dc_req_valid_o && dc_req_ready_i;
  assign req_ready_o    = hs ? NREQ'(1) << g : '0;
  assign dc_req_data_o  = req_data_i[g*REQ_W +: REQ_W];
  assign dc_req_tag_o   = {g, req_tag_i[g*TAG_W +: TAG_W]};
  assign dc_req_abort_o = !rst_i && abort_vld && req_abort_i[abort_sid];
  assign rsp_sid        = dc_rsp_tag_i[SID_W+TAG_W-1 -: SID_W];
  assign rsp_tag_o      = dc_rsp_tag_i[TAG_W-1:0];
  assign rsp_data_o     = dc_rsp_data_i;
  assign rsp_valid_o    = (!rst_i && dc_rsp_valid_i && int'(rsp_sid) < NREQ) ? NREQ'(1) << rsp_sid : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_sid  <= '0;
      abort_vld <= 1'b0;
      abort_sid <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      abort_vld <= hs;
      if (hs) begin
        rr_ptr    <= (int'(g) == NREQ - 1) ? '0 : g + SID_W'(1);
        lock      <= 1'b0;
        abort_sid <= g;
      end else if (dc_req_valid_o) begin
        lock     <= 1'b1;
        lock_sid <= g;
      end
      for (int i = 0; i < NREQ; i++)
        if (req_ready_o[i] && !rsp_valid_o[i] && cnt[i] != CNT_W'(MAX_OUTSTANDING)) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (rsp_valid_o[i] && !req_ready_o[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sargantana_dcache_req_arbiter.sv
// tb_sargantana_dcache_req_arbiter: randomized clients and cache checked against a behavioural arbiter model
module tb_sargantana_dcache_req_arbiter;
  localparam int NREQ = 2, REQ_W = 128, RSP_W = 96, TAG_W = 8, MAXO = 4, SID_W = 1;
`ifdef SARGANTANA_DCACHE_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, req_abort, rsp_valid;
  logic [NREQ*REQ_W-1:0] req_data;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [RSP_W-1:0] rsp_data, dc_rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic dc_req_valid, dc_req_ready, dc_req_abort, dc_rsp_valid;
  logic [REQ_W-1:0] dc_req_data;
  logic [SID_W+TAG_W-1:0] dc_req_tag, dc_rsp_tag;
  always #5 clk = ~clk;
  sargantana_dcache_req_arbiter #(.NREQ(NREQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .TAG_W(TAG_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .req_tag_i(req_tag), .req_abort_i(req_abort), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .dc_req_valid_o(dc_req_valid), .dc_req_ready_i(dc_req_ready),
    .dc_req_data_o(dc_req_data), .dc_req_tag_o(dc_req_tag), .dc_req_abort_o(dc_req_abort),
    .dc_rsp_valid_i(dc_rsp_valid), .dc_rsp_data_i(dc_rsp_data), .dc_rsp_tag_i(dc_rsp_tag)
  );
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  // Reference state: ring position of the next favoured client, in-flight counts, held grant, pending abort.
  int m_rr, m_cnt [NREQ], m_lock, m_lock_sid, m_ab_vld, m_ab_sid;
  bit cv [NREQ];
  logic [REQ_W-1:0] cdata [NREQ];
  logic [TAG_W-1:0] ctag [NREQ];
  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lock_sid = 0; m_ab_vld = 0; m_ab_sid = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_dc_valid"}, 128'(dc_req_valid), 128'(0));
    check({tag, "_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_abort"}, 128'(dc_req_abort), 128'(0));
  endtask
  initial begin
    int eg, bd, d, rsid, pct;
    bit e [NREQ];
    bit ev, hs, rv, any;
    req_valid = '1; req_data = '0; req_tag = '0; req_abort = '1;
    dc_req_ready = 1'b1; dc_rsp_valid = 1'b1; dc_rsp_data = '0; dc_rsp_tag = '0;
    for (int i = 0; i < NREQ; i++) cv[i] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        rst = 1'b1;
        #1 check_quiet("midreset");
        model_reset();
        rst = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!cv[i] && $urandom_range(0, 99) < 70) begin
          cv[i] = 1'b1;
          cdata[i] = {$urandom, $urandom, $urandom, $urandom};
          ctag[i] = TAG_W'($urandom);
        end
        req_valid[i] = cv[i];
        req_data[i*REQ_W +: REQ_W] = cv[i] ? cdata[i] : '0;
        req_tag[i*TAG_W +: TAG_W] = cv[i] ? ctag[i] : '0;
      end
      dc_req_ready = $urandom_range(0, 99) < 70;
      pct = ((c / 300) % 2) ? 60 : 10;
      rv = $urandom_range(0, 99) < pct;
      rsid = int'($urandom_range(0, NREQ - 1));
      dc_rsp_valid = rv;
      dc_rsp_tag = {SID_W'(rsid), TAG_W'($urandom)};
      dc_rsp_data = {$urandom, $urandom, $urandom};
      req_abort = NREQ'($urandom);
      #1;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        e[i] = cv[i] && m_cnt[i] < MAXO;
        any |= e[i];
      end
      ev = m_lock != 0 || any;
      eg = -1;
      if (m_lock != 0) eg = m_lock_sid;
      else if (PRIO && e[0]) eg = 0;
      else begin
        bd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_rr + NREQ) % NREQ;
          if (e[i] && !(PRIO && i == 0) && d < bd) begin bd = d; eg = i; end
        end
      end
      hs = ev && dc_req_ready;
      check("dc_valid", 128'(dc_req_valid), 128'(ev));
      check("ready", 128'(req_ready), hs ? 128'(1) << eg : 128'(0));
      if (ev) begin
        check("dc_tag", 128'(dc_req_tag), (128'(eg) << TAG_W) | 128'(ctag[eg]));
        check("dc_data", 128'(dc_req_data), 128'(cdata[eg]));
      end
      check("abort", 128'(dc_req_abort), 128'(m_ab_vld != 0 && req_abort[m_ab_sid]));
      check("rsp_valid", 128'(rsp_valid), rv ? 128'(1) << rsid : 128'(0));
      check("rsp_tag", 128'(rsp_tag), 128'(dc_rsp_tag[TAG_W-1:0]));
      if (rv) check("rsp_data", 128'(rsp_data), 128'(dc_rsp_data));
      m_ab_vld = hs;
      if (hs) begin
        m_ab_sid = eg;
        m_rr = (eg + 1) % NREQ;
        m_lock = 0;
        cv[eg] = 1'b0;
      end else if (ev) begin
        m_lock = 1;
        m_lock_sid = eg;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (hs && eg == i && !(rv && rsid == i)) m_cnt[i] = (m_cnt[i] < MAXO) ? m_cnt[i] + 1 : m_cnt[i];
        else if (rv && rsid == i && !(hs && eg == i) && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
